// File: rtl/move_pkg.sv
// +--------------------------------------------------------------------+
// | move_pkg : step command codes, move phases and sequencer states    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package move_pkg;

  localparam logic [2:0] OD_NONE  = 3'd0;
  localparam logic [2:0] OD_ENTER = 3'd1;
  localparam logic [2:0] OD_UP    = 3'd2;
  localparam logic [2:0] OD_DOWN  = 3'd3;
  localparam logic [2:0] OD_LEFT  = 3'd4;
  localparam logic [2:0] OD_RIGHT = 3'd5;

  typedef enum logic [1:0] {
    PH_SRC = 2'd0,
    PH_DST = 2'd1,
    PH_ARW = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/move_sequencer_pacer.sv
// +--------------------------------------------------------------------+
// | step_pacer : loadable down-counter flagging the end of a gap       |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module step_pacer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the cycle whose decrement reaches zero, so the follow-on action
  // lands exactly load_val+1 cycles after the load.
  assign expire_o = (count_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/move_sequencer.sv
// +--------------------------------------------------------------------+
// | move_sequencer : plays one Amazons move as paced od/ena steps      |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module move_sequencer
  import move_pkg::*;
#(
  parameter int GAP = 16,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] cur_x,
  input  logic [CW-1:0] cur_y,
  input  logic [CW-1:0] src_x,
  input  logic [CW-1:0] src_y,
  input  logic [CW-1:0] dst_x,
  input  logic [CW-1:0] dst_y,
  input  logic [CW-1:0] arw_x,
  input  logic [CW-1:0] arw_y,
  output logic [2:0]    od,
  output logic          ena,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [CW-1:0] ix_q, ix_d;
  logic [CW-1:0] iy_q, iy_d;
  logic [CW-1:0] sx_q, sy_q, dx_q, dy_q, ax_q, ay_q;
  logic          last_q, last_d;
  logic [2:0]    od_q, od_d;

  logic          w_latch;
  logic          w_pace_load;
  logic          w_pace_clear;
  logic          w_pace_expire;
  logic [CW-1:0] w_tgt_x;
  logic [CW-1:0] w_tgt_y;
  logic [2:0]    w_cmd;

  step_pacer #(
    .W (16)
  ) u_pacer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_pace_load),
    .clear_i    (w_pace_clear),
    .load_val_i (16'(GAP - 1)),
    .expire_o   (w_pace_expire)
  );

  always_comb begin
    w_tgt_x = sx_q;
    w_tgt_y = sy_q;
    case (phase_q)
      PH_DST: begin
        w_tgt_x = dx_q;
        w_tgt_y = dy_q;
      end
      PH_ARW: begin
        w_tgt_x = ax_q;
        w_tgt_y = ay_q;
      end
      default: ;
    endcase
  end

  // Column first, then row, then confirm.
  always_comb begin
    w_cmd = OD_ENTER;
    if (ix_q < w_tgt_x) begin
      w_cmd = OD_RIGHT;
    end else if (ix_q > w_tgt_x) begin
      w_cmd = OD_LEFT;
    end else if (iy_q < w_tgt_y) begin
      w_cmd = OD_DOWN;
    end else if (iy_q > w_tgt_y) begin
      w_cmd = OD_UP;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    ix_d         = ix_q;
    iy_d         = iy_q;
    last_d       = last_q;
    od_d         = od_q;
    w_latch      = 1'b0;
    w_pace_load  = 1'b0;
    w_pace_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          w_latch = 1'b1;
          ix_d    = cur_x;
          iy_d    = cur_y;
          phase_d = PH_SRC;
          last_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        od_d        = w_cmd;
        w_pace_load = 1'b1;
        state_d     = ST_WAIT;
        case (w_cmd)
          OD_RIGHT: ix_d = ix_q + 1'b1;
          OD_LEFT:  ix_d = ix_q - 1'b1;
          OD_DOWN:  iy_d = iy_q + 1'b1;
          OD_UP:    iy_d = iy_q - 1'b1;
          default: begin
            case (phase_q)
              PH_SRC:  phase_d = PH_DST;
              PH_DST:  phase_d = PH_ARW;
              default: last_d  = 1'b1;
            endcase
          end
        endcase
      end
      ST_WAIT: begin
        if (w_pace_expire) begin
          state_d = last_q ? ST_FIN : ST_ISSUE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      od_d         = OD_NONE;
      w_pace_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= PH_SRC;
      ix_q    <= '0;
      iy_q    <= '0;
      last_q  <= 1'b0;
      od_q    <= OD_NONE;
      sx_q    <= '0;
      sy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
      last_q  <= last_d;
      od_q    <= od_d;
      if (w_latch) begin
        sx_q <= src_x;
        sy_q <= src_y;
        dx_q <= dst_x;
        dy_q <= dst_y;
        ax_q <= arw_x;
        ay_q <= arw_y;
      end
    end
  end

  assign ena  = (state_q == ST_ISSUE);
  assign od   = ena ? w_cmd : od_q;
  assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done = (state_q == ST_FIN);

endmodule

`default_nettype wire

// File: tb/tb_move_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_move_sequencer : scoreboard bench for move_sequencer            |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_move_sequencer;
  import move_pkg::*;

  localparam int GAP = 4;
  localparam int CW  = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cur_x = '0, cur_y = '0;
  logic [CW-1:0] src_x = '0, src_y = '0;
  logic [CW-1:0] dst_x = '0, dst_y = '0;
  logic [CW-1:0] arw_x = '0, arw_y = '0;
  logic [2:0]    od;
  logic          ena;
  logic          busy;
  logic          done;

  move_sequencer #(.GAP(GAP), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .src_x (src_x),
    .src_y (src_y),
    .dst_x (dst_x),
    .dst_y (dst_y),
    .arw_x (arw_x),
    .arw_y (arw_y),
    .od    (od),
    .ena   (ena),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       is_done;
    logic [2:0] od;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   last_strobe = -1000;
  int   first_exp   = 0;
  bit   want_first  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or done.
  always @(negedge clk) begin
    if (ena) begin
      if (q.size() == 0) begin
        check("unexpected_strobe", int'(q.size() != 0), 1);
      end else begin
        e = q.pop_front();
        check("strobe_kind", int'(e.is_done), 0);
        check("strobe_od", int'(od), int'(e.od));
        check("busy_on_strobe", int'(busy), 1);
        if (want_first) begin
          check("first_latency", cyc, first_exp);
          want_first = 1'b0;
        end else begin
          check("strobe_gap", cyc - last_strobe, GAP);
        end
      end
      last_strobe = cyc;
    end
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", int'(q.size() != 0), 1);
      end else begin
        e = q.pop_front();
        check("done_kind", int'(e.is_done), 1);
        check("done_gap", cyc - last_strobe, GAP);
        check("busy_with_done", int'(busy), 0);
      end
    end
  end

  task automatic push(input logic [2:0] c, input int n);
    exp_t x;
    x.is_done = 1'b0;
    x.od      = c;
    repeat (n) q.push_back(x);
  endtask

  task automatic push_done();
    exp_t x;
    x.is_done = 1'b1;
    x.od      = OD_NONE;
    q.push_back(x);
  endtask

  task automatic set_coords(input int cx, input int cy, input int sx, input int sy,
                            input int dx, input int dy, input int ax, input int ay);
    cur_x = CW'(cx); cur_y = CW'(cy);
    src_x = CW'(sx); src_y = CW'(sy);
    dst_x = CW'(dx); dst_y = CW'(dy);
    arw_x = CW'(ax); arw_y = CW'(ay);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start      = 1'b1;
    first_exp  = cyc + 1;
    want_first = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_empty(input int limit, input bit perturb);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk); #1;
      n++;
      if (perturb && n == 10) begin
        start = 1'b1;
        set_coords(5, 6, 7, 7, 1, 1, 6, 2);
      end
      if (perturb && n == 11) start = 1'b0;
    end
    check("scoreboard_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_move1();
    push(OD_RIGHT, 2); push(OD_DOWN, 1); push(OD_ENTER, 1);
    push(OD_DOWN, 4);  push(OD_ENTER, 1);
    push(OD_LEFT, 2);  push(OD_ENTER, 1);
    push_done();
  endtask

  initial begin
    // Reset state
    #23;
    check("rst_od", int'(od), 0);
    check("rst_ena", int'(ena), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Reference move: 12 strobes then done
    set_coords(0, 0, 2, 1, 2, 5, 0, 5);
    push_move1();
    pulse_start();
    wait_empty(200, 1'b0);
    idle(2 * GAP);

    // Zero-distance move: three ENTERs only
    set_coords(3, 3, 3, 3, 3, 3, 3, 3);
    push(OD_ENTER, 3); push_done();
    pulse_start();
    wait_empty(100, 1'b0);
    idle(2 * GAP);

    // Full-diagonal corner-to-corner source phase
    set_coords(7, 0, 0, 7, 0, 7, 0, 7);
    push(OD_LEFT, 7); push(OD_DOWN, 7); push(OD_ENTER, 3); push_done();
    pulse_start();
    wait_empty(300, 1'b0);
    idle(2 * GAP);

    // Abort in WAIT after the fifth strobe
    set_coords(0, 0, 2, 1, 2, 5, 0, 5);
    push(OD_RIGHT, 2); push(OD_DOWN, 1); push(OD_ENTER, 1); push(OD_DOWN, 1);
    pulse_start();
    wait_empty(100, 1'b0);
    @(posedge clk); #1;
    check("wait_od_hold", int'(od), int'(OD_DOWN));
    check("wait_ena", int'(ena), 0);
    check("wait_busy", int'(busy), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_ena", int'(ena), 0);
    check("abort_od", int'(od), 0);
    check("abort_done", int'(done), 0);
    idle(4 * GAP);

    // Start and abort together in IDLE: abort wins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    idle(3 * GAP);

    // Restart while busy and live input changes mid-move are ignored
    set_coords(0, 0, 2, 1, 2, 5, 0, 5);
    push_move1();
    pulse_start();
    wait_empty(200, 1'b1);
    idle(2 * GAP);

    // Asynchronous reset during ISSUE
    set_coords(0, 0, 2, 1, 2, 5, 0, 5);
    push(OD_RIGHT, 1);
    pulse_start();
    wait_empty(10, 1'b0);
    check("ena_before_reset", int'(ena), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ena", int'(ena), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_od", int'(od), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5 * GAP);
    check("post_reset_idle_busy", int'(busy), 0);

    // Normal operation resumes after reset
    set_coords(3, 3, 3, 3, 3, 3, 3, 3);
    push(OD_ENTER, 3); push_done();
    pulse_start();
    wait_empty(100, 1'b0);
    idle(2 * GAP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
